// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing a single-port data memory between two requesters,
// with registered per-port read data and a sticky out-of-range flag.
module dmem_arbiter #(
  parameter int unsigned DEPTH = 256
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req0,
  input  logic        Req1,
  input  logic        We0,
  input  logic        We1,
  input  logic [31:0] Addr0,
  input  logic [31:0] Addr1,
  input  logic [31:0] WrData0,
  input  logic [31:0] WrData1,
  output logic        Gnt0,
  output logic        Gnt1,
  output logic [31:0] RdData0,
  output logic [31:0] RdData1,
  output logic        RdValid0,
  output logic        RdValid1,
  output logic        AddrErr,
  output logic [31:0] DmemAddr,
  output logic        DmemWrite,
  output logic [31:0] DmemWrData,
  input  logic [31:0] DmemRdData
);
  localparam logic [31:0] LIMIT = 32'(DEPTH * 4);
  logic        last_q, last_d;
  logic        rd_valid0_q, rd_valid0_d, rd_valid1_q, rd_valid1_d;
  logic [31:0] rd_data0_q, rd_data0_d, rd_data1_q, rd_data1_d;
  logic        addr_err_q, addr_err_d;
  logic        any, win_we, in_range;
  logic [31:0] win_addr, win_wd, rd_word;
  // On contention the port that did not win last time gets the access.
  assign Gnt0 = ~Reset & Req0 & (~Req1 | last_q);
  assign Gnt1 = ~Reset & Req1 & (~Req0 | ~last_q);
  assign any      = Gnt0 | Gnt1;
  assign win_addr = Gnt1 ? Addr1 : Addr0;
  assign win_we   = Gnt1 ? We1 : We0;
  assign win_wd   = Gnt1 ? WrData1 : WrData0;
  assign in_range = win_addr < LIMIT;
  assign rd_word  = in_range ? DmemRdData : '0;
  assign DmemAddr   = any ? win_addr : '0;
  assign DmemWrData = any ? win_wd : '0;
  assign DmemWrite  = any & win_we & in_range;
  always_comb begin
    rd_valid0_d = Gnt0 & ~We0;
    rd_valid1_d = Gnt1 & ~We1;
    rd_data0_d  = rd_valid0_d ? rd_word : rd_data0_q;
    rd_data1_d  = rd_valid1_d ? rd_word : rd_data1_q;
    last_d      = any ? Gnt1 : last_q;
    addr_err_d  = addr_err_q | (any & ~in_range);
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      last_q      <= 1'b1;
      rd_valid0_q <= 1'b0;
      rd_valid1_q <= 1'b0;
      rd_data0_q  <= '0;
      rd_data1_q  <= '0;
      addr_err_q  <= 1'b0;
    end else begin
      last_q      <= last_d;
      rd_valid0_q <= rd_valid0_d;
      rd_valid1_q <= rd_valid1_d;
      rd_data0_q  <= rd_data0_d;
      rd_data1_q  <= rd_data1_d;
      addr_err_q  <= addr_err_d;
    end
  end
  assign RdValid0 = rd_valid0_q;
  assign RdValid1 = rd_valid1_q;
  assign RdData0  = rd_data0_q;
  assign RdData1  = rd_data1_q;
  assign AddrErr  = addr_err_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven cycle vectors against a behavioural 256x32 memory,
// then direct inspection of memory contents for blocked and overwritten writes.
module tb_dmem_arbiter;
  logic        Clk = 1'b0;
  logic        Reset, Req0, Req1, We0, We1;
  logic [31:0] Addr0, Addr1, WrData0, WrData1;
  logic        Gnt0, Gnt1, RdValid0, RdValid1, AddrErr, DmemWrite;
  logic [31:0] RdData0, RdData1, DmemAddr, DmemWrData, DmemRdData;
  logic [31:0] mem [256];
  int passed = 0;
  int total = 0;

  typedef struct {
    logic rst, r0, w0; logic [31:0] a0, d0;
    logic r1, w1; logic [31:0] a1, d1;
    logic g0, g1, dwe; logic [31:0] da;
    logic v0; logic [31:0] q0;
    logic v1; logic [31:0] q1;
    logic err;
  } vec_t;
  vec_t vec [23];

  dmem_arbiter #(.DEPTH(256)) dut (
    .Clk(Clk), .Reset(Reset), .Req0(Req0), .Req1(Req1), .We0(We0), .We1(We1),
    .Addr0(Addr0), .Addr1(Addr1), .WrData0(WrData0), .WrData1(WrData1),
    .Gnt0(Gnt0), .Gnt1(Gnt1), .RdData0(RdData0), .RdData1(RdData1),
    .RdValid0(RdValid0), .RdValid1(RdValid1), .AddrErr(AddrErr),
    .DmemAddr(DmemAddr), .DmemWrite(DmemWrite), .DmemWrData(DmemWrData),
    .DmemRdData(DmemRdData)
  );

  always #5 Clk = ~Clk;
  assign DmemRdData = DmemWrite ? '0 : mem[DmemAddr[9:2]];
  always @(posedge Clk) if (DmemWrite) mem[DmemAddr[9:2]] <= DmemWrData;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s got %h want %h", n, act, exp);
    else passed++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + 32'(i);
    mem[2] = 32'hDEAD_BEEF;
    // rst r0 w0 a0 d0 | r1 w1 a1 d1 | g0 g1 dwe daddr | v0 q0 | v1 q1 | err
    vec[0]  = '{1,1,1,32'h000,32'hFFFF_FFFF, 1,0,32'h000,0, 0,0,0,32'h000, 0,32'h0,           0,32'h0,           0};
    vec[1]  = '{0,1,0,32'h008,0,             0,0,32'h000,0, 1,0,0,32'h008, 0,32'h0,           0,32'h0,           0};
    vec[2]  = '{0,0,0,32'h000,0,             1,1,32'h010,32'h1234_5678, 0,1,1,32'h010, 1,32'hDEAD_BEEF, 0,32'h0, 0};
    vec[3]  = '{0,1,0,32'h010,0,             0,0,32'h000,0, 1,0,0,32'h010, 0,32'hDEAD_BEEF,  0,32'h0,           0};
    vec[4]  = '{0,1,0,32'h000,0,             0,0,32'h000,0, 1,0,0,32'h000, 1,32'h1234_5678,  0,32'h0,           0};
    vec[5]  = '{0,1,0,32'h004,0,             0,0,32'h000,0, 1,0,0,32'h004, 1,32'hA000_0000,  0,32'h0,           0};
    vec[6]  = '{0,0,0,32'h000,0,             0,0,32'h000,0, 0,0,0,32'h000, 1,32'hA000_0001,  0,32'h0,           0};
    vec[7]  = '{1,0,0,32'h000,0,             0,0,32'h000,0, 0,0,0,32'h000, 0,32'hA000_0001,  0,32'h0,           0};
    vec[8]  = '{0,1,0,32'h004,0,             1,0,32'h00C,0, 1,0,0,32'h004, 0,32'h0,           0,32'h0,           0};
    vec[9]  = '{0,1,0,32'h004,0,             1,0,32'h00C,0, 0,1,0,32'h00C, 1,32'hA000_0001,  0,32'h0,           0};
    vec[10] = '{0,1,0,32'h004,0,             1,0,32'h00C,0, 1,0,0,32'h004, 0,32'hA000_0001,  1,32'hA000_0003,  0};
    vec[11] = '{0,1,0,32'h004,0,             1,0,32'h00C,0, 0,1,0,32'h00C, 1,32'hA000_0001,  0,32'hA000_0003,  0};
    vec[12] = '{0,1,0,32'h004,0,             1,0,32'h00C,0, 1,0,0,32'h004, 0,32'hA000_0001,  1,32'hA000_0003,  0};
    vec[13] = '{0,1,0,32'h004,0,             1,0,32'h00C,0, 0,1,0,32'h00C, 1,32'hA000_0001,  0,32'hA000_0003,  0};
    vec[14] = '{0,1,1,32'h020,32'hAAAA_0000, 1,1,32'h020,32'hBBBB_1111, 1,0,1,32'h020, 0,32'hA000_0001, 1,32'hA000_0003, 0};
    vec[15] = '{0,0,0,32'h000,0,             1,1,32'h020,32'hBBBB_1111, 0,1,1,32'h020, 0,32'hA000_0001, 0,32'hA000_0003, 0};
    vec[16] = '{0,1,0,32'h020,0,             0,0,32'h000,0, 1,0,0,32'h020, 0,32'hA000_0001,  0,32'hA000_0003,  0};
    vec[17] = '{0,1,1,32'h400,32'hCAFE_F00D, 0,0,32'h000,0, 1,0,0,32'h400, 1,32'hBBBB_1111,  0,32'hA000_0003,  0};
    vec[18] = '{0,0,0,32'h000,0,             1,0,32'h404,0, 0,1,0,32'h404, 0,32'hBBBB_1111,  0,32'hA000_0003,  1};
    vec[19] = '{0,1,0,32'h008,0,             0,0,32'h000,0, 1,0,0,32'h008, 0,32'hBBBB_1111,  1,32'h0,           1};
    vec[20] = '{1,1,0,32'h008,0,             1,0,32'h00C,0, 0,0,0,32'h000, 1,32'hDEAD_BEEF,  0,32'h0,           1};
    vec[21] = '{0,1,0,32'h008,0,             1,0,32'h00C,0, 1,0,0,32'h008, 0,32'h0,           0,32'h0,           0};
    vec[22] = '{0,0,0,32'h000,0,             0,0,32'h000,0, 0,0,0,32'h000, 1,32'hDEAD_BEEF,  0,32'h0,           0};
    {Reset, Req0, Req1, We0, We1} = 5'b10000;
    {Addr0, Addr1, WrData0, WrData1} = '0;
    @(posedge Clk);
    for (int i = 0; i < 23; i++) begin
      @(negedge Clk);
      Reset = vec[i].rst; Req0 = vec[i].r0; We0 = vec[i].w0; Addr0 = vec[i].a0; WrData0 = vec[i].d0;
      Req1 = vec[i].r1; We1 = vec[i].w1; Addr1 = vec[i].a1; WrData1 = vec[i].d1;
      #1;
      chk($sformatf("r%0d gnt0", i), 32'(Gnt0), 32'(vec[i].g0));
      chk($sformatf("r%0d gnt1", i), 32'(Gnt1), 32'(vec[i].g1));
      chk($sformatf("r%0d dmem_write", i), 32'(DmemWrite), 32'(vec[i].dwe));
      chk($sformatf("r%0d dmem_addr", i), DmemAddr, vec[i].da);
      chk($sformatf("r%0d rd_valid0", i), 32'(RdValid0), 32'(vec[i].v0));
      chk($sformatf("r%0d rd_data0", i), RdData0, vec[i].q0);
      chk($sformatf("r%0d rd_valid1", i), 32'(RdValid1), 32'(vec[i].v1));
      chk($sformatf("r%0d rd_data1", i), RdData1, vec[i].q1);
      chk($sformatf("r%0d addr_err", i), 32'(AddrErr), 32'(vec[i].err));
    end
    @(negedge Clk);
    {Req0, Req1} = 2'b00;
    #1;
    chk("mem0 untouched by blocked writes", mem[0], 32'hA000_0000);
    chk("mem4 port1 write", mem[4], 32'h1234_5678);
    chk("mem8 second grantee wins", mem[8], 32'hBBBB_1111);
    chk("mem1 untouched", mem[1], 32'hA000_0001);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port round-robin arbiter that shares the single-port 256×32 data memory between the CPU data port (port 0) and a loader/debug port (port 1). It sits between the requesters and the data memory and drives the memory's address, write-enable and write-data inputs. It returns registered read data with a valid strobe to whichever port won the access. Out-of-range accesses are blocked and flagged.

## Interface

- `DEPTH`, 256 — memory depth in 32-bit words; legal byte addresses are 0 .. DEPTH*4-1.
- `Clk` in 1 — single clock, rising edge.
- `Reset` in 1 — synchronous, active-high.
- `Req0`, `Req1` in 1 — access request from port 0 / port 1.
- `We0`, `We1` in 1 — 1 = write, 0 = read; qualified by ReqN.
- `Addr0`, `Addr1` in 32 — byte address; bits [1:0] ignored.
- `WrData0`, `WrData1` in 32 — write data.
- `Gnt0`, `Gnt1` out 1 — access accepted this cycle (combinational, one-hot or zero).
- `RdData0`, `RdData1` out 32 — registered read data.
- `RdValid0`, `RdValid1` out 1 — RdDataN valid; one-cycle pulse.
- `AddrErr` out 1 — sticky out-of-range flag.
- `DmemAddr` out 32 — to memory; byte address of the winner.
- `DmemWrite` out 1 — to memory write enable.
- `DmemWrData` out 32 — to memory write data.
- `DmemRdData` in 32 — from memory; combinational read, 0 while DmemWrite=1.

## Operation

- State: `Last` (1 bit, last granted port), `RdValidN`/`RdDataN` registers, `AddrErr`.
- Selection per cycle:
  - Only one Req high: that port wins.
  - Both high: the port ≠ Last wins.
  - Neither high: no winner; all memory outputs are 0 and DmemWrite=0.
- Range check: winner with Addr ≥ DEPTH*4 still receives Gnt, but DmemWrite is forced to 0, the read returns 0 with RdValid pulsed, and AddrErr sets.
- Grant: GntN=1 for the winner in the same cycle; the transaction completes at the following rising edge. The requester must hold Req/We/Addr/WrData stable until it samples GntN=1. It may deassert or issue a new request in the next cycle.
- Write: DmemAddr=Addr, DmemWrData=WrData, DmemWrite=1; the memory commits at the edge. No RdValid pulse.
- Read: DmemAddr=Addr, DmemWrite=0; DmemRdData is captured into RdDataN at the edge and RdValidN=1 for the next cycle.
- RdDataN holds its value until that port's next read; it is not cleared by writes or by the other port's reads.
- Last updates to the winner at every edge with a grant and holds otherwise.
- AddrErr stays 1 until Reset.
- Gnt0 and Gnt1 are never both 1.

## Timing

- Reset values (edge with Reset=1): Last=1 (port 0 wins the first contention), RdValid0/1=0, RdData0/1=0, AddrErr=0.
- While Reset=1, Gnt0/1=0 and DmemWrite=0 regardless of Req.
- Read latency: request cycle t (GntN=1) → RdValidN=1 and data in cycle t+1.
- Throughput: one access per cycle total. Back-to-back reads from the same port with no contention complete every cycle, with RdValid high continuously.
- Contention: the ports alternate every cycle. A continuously requesting port waits at most 1 cycle.
- Reset asserted in the cycle after a granted read: RdValid is cleared and the pending read data is discarded.
- Reset asserted in a grant cycle: no grant, no write.
- Req dropped without a grant: no side effects.

## Test plan

- Reset, then Req0 read Addr0=0x8 with memory word 2 = 0xDEADBEEF → Gnt0=1 in the same cycle; next cycle RdValid0=1, RdData0=0xDEADBEEF; RdValid1=0.
- Req1 write Addr1=0x10, WrData1=0x12345678, then Req0 read 0x10 → Gnt1 then Gnt0; RdData0=0x12345678 one cycle after Gnt0.
- Both ports hold read requests for 6 cycles after reset → grants 0,1,0,1,0,1; each RdValid pulses on alternate cycles with the correct words.
- Req0 write to Addr0=0x400 (DEPTH=256) → Gnt0=1, DmemWrite=0, memory unchanged, AddrErr=1 and remains 1 until Reset.
- Reset asserted in the cycle RdValid0 would rise → RdValid0=0, RdData0=0, Last=1; the next contended cycle grants port 0.
- Both Req with We0=1 and We1=1 to the same address 0x20, with data A and B → the first grant's data is written, then overwritten by the second; a final read returns the second grantee's data.
